cmp_window_stats: RTL and testbench

Windowed statistics collector that sits directly downstream of the N-bit magnitude comparator. It accepts one operand pair and its Lesser/Greater/Equal flags per handshake. Over a fixed window of WINDOW samples it counts each outcome, counts flag-integrity errors and tracks the largest winning operand. At the end of each window it emits one registered summary record through a valid/ready output.

---
 rtl/cmp_window_stats.sv | 165 ++++++++++++++++
 tb/tb_cmp_window_stats.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_stats.sv
`timescale 1ns/1ps
// Windowed statistics for the N-bit magnitude comparator: per-window outcome
// counts, flag-integrity errors and largest winning operand, one record per window.
module cmp_window_stats #(
  parameter int N      = 32,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             Lesser,
  input  logic             Greater,
  input  logic             Equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     max_val
);

  typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_lt_q, acc_lt_d;
  logic [CNT_W-1:0] acc_gt_q, acc_gt_d;
  logic [CNT_W-1:0] acc_eq_q, acc_eq_d;
  logic [CNT_W-1:0] acc_err_q, acc_err_d;
  logic [N-1:0]     acc_max_q, acc_max_d;

  logic [CNT_W-1:0] rec_lt_q, rec_gt_q, rec_eq_q, rec_err_q;
  logic [N-1:0]     rec_max_q;

  logic             accept;
  logic             last;
  logic [3:0]       inc;
  logic [N-1:0]     winner;
  logic [CNT_W-1:0] lt_next, gt_next, eq_next, err_next, idx_next;
  logic [N-1:0]     max_next;

  // Returns {err, eq, gt, lt}; anything other than exactly one flag is an error.
  function automatic logic [3:0] classify(input logic l, input logic g, input logic e);
    logic [3:0] r;
    case ({l, g, e})
      3'b100:  r = 4'b0001;
      3'b010:  r = 4'b0010;
      3'b001:  r = 4'b0100;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] umax(input logic [N-1:0] x, input logic [N-1:0] y);
    return (x > y) ? x : y;
  endfunction

  assign accept   = in_valid && in_ready && !clear;
  assign last     = accept && (idx_q == CNT_W'(WINDOW - 1));
  assign inc      = classify(Lesser, Greater, Equal);
  assign winner   = Greater ? a : b;

  assign lt_next  = acc_lt_q  + CNT_W'(inc[0]);
  assign gt_next  = acc_gt_q  + CNT_W'(inc[1]);
  assign eq_next  = acc_eq_q  + CNT_W'(inc[2]);
  assign err_next = acc_err_q + CNT_W'(inc[3]);
  assign idx_next = idx_q + CNT_W'(1);
  assign max_next = umax(acc_max_q, winner);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last)      state_d = REPORT;
      REPORT:  if (out_ready) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
    if (clear) state_d = COLLECT;
  end

  // Output decode from state only
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == REPORT);
  end

  // Accumulators restart at zero after the window-closing accept
  always_comb begin
    idx_d     = idx_q;
    acc_lt_d  = acc_lt_q;
    acc_gt_d  = acc_gt_q;
    acc_eq_d  = acc_eq_q;
    acc_err_d = acc_err_q;
    acc_max_d = acc_max_q;
    if (clear || last) begin
      idx_d     = '0;
      acc_lt_d  = '0;
      acc_gt_d  = '0;
      acc_eq_d  = '0;
      acc_err_d = '0;
      acc_max_d = '0;
    end else if (accept) begin
      idx_d     = idx_next;
      acc_lt_d  = lt_next;
      acc_gt_d  = gt_next;
      acc_eq_d  = eq_next;
      acc_err_d = err_next;
      acc_max_d = max_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      acc_lt_q  <= '0;
      acc_gt_q  <= '0;
      acc_eq_q  <= '0;
      acc_err_q <= '0;
      acc_max_q <= '0;
    end else begin
      idx_q     <= idx_d;
      acc_lt_q  <= acc_lt_d;
      acc_gt_q  <= acc_gt_d;
      acc_eq_q  <= acc_eq_d;
      acc_err_q <= acc_err_d;
      acc_max_q <= acc_max_d;
    end
  end

  // Record registers include the final sample's contribution and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_lt_q  <= '0;
      rec_gt_q  <= '0;
      rec_eq_q  <= '0;
      rec_err_q <= '0;
      rec_max_q <= '0;
    end else if (last) begin
      rec_lt_q  <= lt_next;
      rec_gt_q  <= gt_next;
      rec_eq_q  <= eq_next;
      rec_err_q <= err_next;
      rec_max_q <= max_next;
    end
  end

  assign lt_count  = rec_lt_q;
  assign gt_count  = rec_gt_q;
  assign eq_count  = rec_eq_q;
  assign err_count = rec_err_q;
  assign max_val   = rec_max_q;

endmodule

// File: tb/tb_cmp_window_stats.sv
`timescale 1ns/1ps
// Scoreboard bench for cmp_window_stats (N=32, WINDOW=4): a behavioural model
// pushes expected records on accept; a negedge monitor pops them on handshake.
module tb_cmp_window_stats;

  localparam int N = 32;
  localparam int WINDOW = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N-1:0] a = '0, b = '0;
  logic Lesser = 1'b0, Greater = 1'b0, Equal = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [CNT_W-1:0] lt_count, gt_count, eq_count, err_count;
  logic [N-1:0] max_val;

  cmp_window_stats #(.N(N), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .Lesser(Lesser), .Greater(Greater), .Equal(Equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .lt_count(lt_count), .gt_count(gt_count), .eq_count(eq_count),
    .err_count(err_count), .max_val(max_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lt, gt, eq, err;
    logic [31:0] mx;
  } rec_t;

  rec_t expq[$];
  int   n_chk = 0;
  int   n_err = 0;

  int          m_idx = 0, m_lt = 0, m_gt = 0, m_eq = 0, m_err = 0;
  logic [31:0] m_max = '0;

  int   cyc = 0;
  logic prev_ov = 1'b0;
  bit   stream_on = 1'b0;
  int   rises[$];

  localparam logic [2:0] FL = 3'b100, FG = 3'b010, FE = 3'b001;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_lt = 0; m_gt = 0; m_eq = 0; m_err = 0; m_max = '0;
  endtask

  task automatic model_accept(input logic [31:0] sa, input logic [31:0] sb, input logic [2:0] f);
    logic [31:0] w;
    rec_t r;
    case (f)
      FL:      m_lt++;
      FG:      m_gt++;
      FE:      m_eq++;
      default: m_err++;
    endcase
    w = f[1] ? sa : sb;
    if (w > m_max) m_max = w;
    m_idx++;
    if (m_idx == WINDOW) begin
      r.lt = 8'(m_lt); r.gt = 8'(m_gt); r.eq = 8'(m_eq); r.err = 8'(m_err); r.mx = m_max;
      expq.push_back(r);
      model_clear();
    end
  endtask

  // Presents a sample and holds it until accepted; leaves in_valid high.
  task automatic send(input logic [31:0] sa, input logic [31:0] sb, input logic [2:0] f);
    bit got = 1'b0;
    a = sa; b = sb; {Lesser, Greater, Equal} = f; in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = in_ready && !clear && rst_n;
      @(posedge clk); #1;
    end
    if (!got) chk_val("send_timeout", 0, 1);
    else model_accept(sa, sb, f);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: record handshake compare and out_valid rise timing
  always @(negedge clk) begin
    rec_t r;
    cyc++;
    if (stream_on && rst_n && out_valid && !prev_ov) rises.push_back(cyc);
    prev_ov = rst_n && out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) chk_val("unexpected_record", 1, 0);
      else begin
        r = expq.pop_front();
        chk_val("lt_count",  64'(lt_count),  64'(r.lt));
        chk_val("gt_count",  64'(gt_count),  64'(r.gt));
        chk_val("eq_count",  64'(eq_count),  64'(r.eq));
        chk_val("err_count", 64'(err_count), 64'(r.err));
        chk_val("max_val",   64'(max_val),   64'(r.mx));
      end
    end
  end

  initial begin
    logic [7:0]  h_lt;
    logic [31:0] h_max;
    int          waitn;

    // Reset state
    #12;
    chk_val("rst_out_valid", 64'(out_valid), 0);
    chk_val("rst_in_ready",  64'(in_ready), 1);
    chk_val("rst_lt",        64'(lt_count), 0);
    chk_val("rst_max",       64'(max_val), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic window: lt=2 gt=1 eq=1 max=777
    send(2, 2, FE);
    send(22, 444, FL);
    send(444, 555, FL);
    send(777, 111, FG);
    in_valid = 1'b0;
    chk_val("basic_ov_rise", 64'(out_valid), 1);
    chk_val("basic_max_now", 64'(max_val), 777);
    @(posedge clk); #1;
    chk_val("basic_ov_pulse", 64'(out_valid), 0);
    chk_val("basic_in_ready", 64'(in_ready), 1);
    idle(2);

    // Flag errors: eq=2 err=2 max=8888
    send(5, 5, FE);
    send(9, 3, 3'b110);
    send(1, 2, 3'b000);
    send(8888, 8888, FE);
    idle(3);

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    send(10, 20, FL);
    send(30, 20, FG);
    send(7, 7, FE);
    send(40, 50, FL);
    h_lt = lt_count; h_max = max_val;
    fork
      begin
        send(100, 1, FG);
        send(2, 300, FL);
        send(6, 6, FE);
        send(9, 9, 3'b111);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk_val("bp_out_valid", 64'(out_valid), 1);
          chk_val("bp_in_ready",  64'(in_ready), 0);
          chk_val("bp_lt_stable", 64'(lt_count), 64'(h_lt));
          chk_val("bp_max_stable", 64'(max_val), 64'(h_max));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_val("bp_ov_drop", 64'(out_valid), 0);
        chk_val("bp_ready_back", 64'(in_ready), 1);
      end
    join
    idle(3);

    // clear mid-window with a sample present
    send(1000, 5, FG);
    send(3, 4000, FL);
    send(50, 50, FE);
    a = 32'hDEAD_BEEF; b = 0; {Lesser, Greater, Equal} = FG;
    in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 0, FG);
    idle(3);

    // Async reset while a record is pending
    out_ready = 1'b0;
    send(11, 12, FL);
    send(13, 12, FG);
    send(14, 14, FE);
    send(15, 16, FL);
    in_valid = 1'b0;
    chk_val("ar_pre_ov", 64'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("ar_ov",  64'(out_valid), 0);
    chk_val("ar_lt",  64'(lt_count), 0);
    chk_val("ar_gt",  64'(gt_count), 0);
    chk_val("ar_eq",  64'(eq_count), 0);
    chk_val("ar_max", 64'(max_val), 0);
    expq.delete();
    model_clear();
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_val("ar_in_ready", 64'(in_ready), 1);
    send(21, 20, FG);
    send(22, 23, FL);
    send(25, 25, FE);
    send(26, 24, FG);
    idle(3);

    // Continuous streaming, 3 windows
    stream_on = 1'b1;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: rf = FL;
        1: rf = FG;
        2: rf = FE;
        default: rf = 3'($urandom_range(0, 7));
      endcase
      send(ra, rb, rf);
    end
    idle(3);
    stream_on = 1'b0;
    chk_val("stream_rises", 64'(rises.size()), 3);
    for (int i = 1; i < rises.size(); i++)
      chk_val("stream_period", 64'(rises[i] - rises[i-1]), 5);

    waitn = 0;
    while (expq.size() != 0 && waitn < 20) begin @(posedge clk); waitn++; end
    chk_val("scoreboard_empty", 64'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
